// File: rtl/disp_sequencer.sv
// disp_sequencer: display-mux sequencer for the word game.
// Walks logout -> level select -> play -> score -> top-ID/top-score rotation.
// Optional feature: define DISP_SEQ_AUTO_LOGOUT_EN to build an idle counter that
// returns LSEL/TOPID/TOPSC to OUT after IDLE_TICKS quiet ticks.
//
// state | meaning
// OUT   | logged out, waiting for loginOk                  (controlSig 0)
// LSEL  | level select                                     (controlSig 1)
// PLAY  | game running, timeLeft counts down on tick       (controlSig 2)
// SCORE | player score shown for SCORE_TICKS ticks         (controlSig 3)
// TOPID | top player ID, alternates with TOPSC             (controlSig 4)
// TOPSC | top score, alternates with TOPID                 (controlSig 5)

module disp_sequencer #(
    parameter int GAME_SECONDS = 60,
    parameter int SCORE_TICKS  = 3,
    parameter int ALT_TICKS    = 2,
    parameter int IDLE_TICKS   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       loginOk,
    input  logic       logoutReq,
    input  logic       levelGo,
    input  logic       gameEnd,
    output logic [2:0] controlSig,
    output logic [5:0] timeLeft,
    output logic       gameActive,
    output logic       timeUp
);

    localparam logic [2:0] S_OUT   = 3'd0;
    localparam logic [2:0] S_LSEL  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_SCORE = 3'd3;
    localparam logic [2:0] S_TOPID = 3'd4;
    localparam logic [2:0] S_TOPSC = 3'd5;

    localparam int PH_MAX_A = (SCORE_TICKS > ALT_TICKS) ? SCORE_TICKS : ALT_TICKS;
    localparam int PH_MAX   = (PH_MAX_A > IDLE_TICKS) ? PH_MAX_A : IDLE_TICKS;
    localparam int PH_W     = $clog2(PH_MAX + 1);

    logic [2:0]      r_state;
    logic [5:0]      r_time_left;
    logic            r_game_active;
    logic            r_time_up;
    logic [PH_W-1:0] r_phase;

    logic [2:0]      w_state_nxt;
    logic [5:0]      w_time_left_nxt;
    logic            w_time_up_nxt;
    logic            w_game_active_nxt;
    logic            w_final_tick;
    logic            w_score_done;
    logic            w_alt_done;
    logic            w_idle_hit;

    assign w_final_tick = (r_state == S_PLAY) && tick && (r_time_left == 6'd1);
    assign w_score_done = tick && (r_phase == PH_W'(SCORE_TICKS - 1));
    assign w_alt_done   = tick && (r_phase == PH_W'(ALT_TICKS - 1));

`ifdef DISP_SEQ_AUTO_LOGOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              w_idle_state;
    logic              w_activity;

    assign w_idle_state = (r_state == S_LSEL) || (r_state == S_TOPID) || (r_state == S_TOPSC);
    assign w_activity   = loginOk || levelGo || logoutReq;
    assign w_idle_hit   = w_idle_state && !w_activity && tick &&
                          (r_idle == IDLE_W'(IDLE_TICKS - 1));

    // Idle counter: runs on ticks in the idle-watched states, any user input restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle <= '0;
        end else if (!w_idle_state || w_activity) begin
            r_idle <= '0;
        end else if (tick && (r_idle != IDLE_W'(IDLE_TICKS))) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_idle_hit = 1'b0;
`endif

    // State register plus registered outputs and the phase counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_OUT;
            r_time_left   <= '0;
            r_game_active <= 1'b0;
            r_time_up     <= 1'b0;
            r_phase       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_time_left   <= w_time_left_nxt;
            r_game_active <= w_game_active_nxt;
            r_time_up     <= w_time_up_nxt;
            if (w_state_nxt != r_state) begin
                r_phase <= '0;
            end else if (tick && (r_phase != PH_W'(PH_MAX))) begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // Next-state decode; logout beats everything, then events, then tick-driven moves.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state > S_TOPSC) begin
            w_state_nxt = S_OUT;
        end else if (logoutReq && (r_state != S_OUT)) begin
            w_state_nxt = S_OUT;
        end else begin
            case (r_state)
                S_OUT:   if (loginOk) w_state_nxt = S_LSEL;
                S_LSEL: begin
                    if (levelGo)         w_state_nxt = S_PLAY;
                    else if (w_idle_hit) w_state_nxt = S_OUT;
                end
                S_PLAY:  if (w_final_tick || gameEnd) w_state_nxt = S_SCORE;
                S_SCORE: begin
                    if (levelGo)           w_state_nxt = S_LSEL;
                    else if (w_score_done) w_state_nxt = S_TOPID;
                end
                S_TOPID: begin
                    if (levelGo)         w_state_nxt = S_LSEL;
                    else if (w_idle_hit) w_state_nxt = S_OUT;
                    else if (w_alt_done) w_state_nxt = S_TOPSC;
                end
                S_TOPSC: begin
                    if (levelGo)         w_state_nxt = S_LSEL;
                    else if (w_idle_hit) w_state_nxt = S_OUT;
                    else if (w_alt_done) w_state_nxt = S_TOPID;
                end
                default: w_state_nxt = S_OUT;
            endcase
        end
    end

    // Output decode: timer load/decrement/freeze and the one-cycle timeUp pulse.
    always_comb begin
        w_time_left_nxt   = r_time_left;
        w_time_up_nxt     = 1'b0;
        w_game_active_nxt = (w_state_nxt == S_PLAY);
        if (r_state > S_TOPSC) begin
            w_time_left_nxt = '0;
        end else if (logoutReq && (r_state != S_OUT)) begin
            w_time_left_nxt = '0;
        end else if ((r_state == S_LSEL) && levelGo) begin
            w_time_left_nxt = 6'(GAME_SECONDS);
        end else if (w_final_tick) begin
            w_time_left_nxt = '0;
            w_time_up_nxt   = 1'b1;
        end else if ((r_state == S_PLAY) && tick && !gameEnd && (r_time_left != 6'd0)) begin
            // gameEnd with a non-final tick freezes the timer: the event wins.
            w_time_left_nxt = r_time_left - 6'd1;
        end
    end

    assign controlSig = r_state;
    assign timeLeft   = r_time_left;
    assign gameActive = r_game_active;
    assign timeUp     = r_time_up;

endmodule

// File: tb/tb_disp_sequencer.sv
// Directed bench for disp_sequencer with default parameters.
module tb_disp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       loginOk;
    logic       logoutReq;
    logic       levelGo;
    logic       gameEnd;
    logic [2:0] controlSig;
    logic [5:0] timeLeft;
    logic       gameActive;
    logic       timeUp;

    int n_cmp = 0;
    int n_bad = 0;
    int n_up  = 0;

    disp_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .loginOk    (loginOk),
        .logoutReq  (logoutReq),
        .levelGo    (levelGo),
        .gameEnd    (gameEnd),
        .controlSig (controlSig),
        .timeLeft   (timeLeft),
        .gameActive (gameActive),
        .timeUp     (timeUp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs, take the edge, clear, leave sampling point at edge+1.
    task automatic drive(input logic t, input logic li, input logic lo,
                         input logic lg, input logic ge);
        tick = t; loginOk = li; logoutReq = lo; levelGo = lg; gameEnd = ge;
        @(posedge clk);
        #1;
        tick = 0; loginOk = 0; logoutReq = 0; levelGo = 0; gameEnd = 0;
    endtask

    task automatic do_tick();
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic n_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    initial begin
        rst = 0; tick = 0; loginOk = 0; logoutReq = 0; levelGo = 0; gameEnd = 0;
        #12;
        chk("rst_cs", controlSig, 0);
        chk("rst_tl", timeLeft, 0);
        chk("rst_ga", gameActive, 0);
        chk("rst_tu", timeUp, 0);
        @(posedge clk); #1;
        rst = 1;
        drive(0, 0, 0, 0, 0);

        // events ignored in OUT
        drive(1, 0, 0, 1, 1);
        chk("out_ign", controlSig, 0);
        drive(0, 1, 0, 0, 0);
        chk("login_cs", controlSig, 1);
        drive(0, 0, 0, 1, 0);
        chk("go_cs", controlSig, 2);
        chk("go_tl", timeLeft, 60);
        chk("go_ga", gameActive, 1);

        // full countdown
        for (int i = 0; i < 60; i++) begin
            drive(1, 0, 0, 0, 0);
            chk("cnt_tl", timeLeft, 59 - i);
            chk("cnt_tu", timeUp, (i == 59) ? 1 : 0);
            if (timeUp) n_up++;
            drive(0, 0, 0, 0, 0);
            chk("cnt_tu_gap", timeUp, 0);
            if (timeUp) n_up++;
        end
        chk("tu_once", n_up, 1);
        chk("end_cs", controlSig, 3);
        chk("end_ga", gameActive, 0);
        n_ticks(2);
        chk("score_hold", controlSig, 3);
        do_tick();
        chk("score_top", controlSig, 4);
        do_tick();
        chk("topid_hold", controlSig, 4);
        do_tick();
        chk("topsc", controlSig, 5);
        n_ticks(2);
        chk("topid_again", controlSig, 4);
        n_ticks(2);
        chk("topsc_again", controlSig, 5);

        // play again, gameEnd at 17
        drive(1, 0, 0, 1, 0);
        chk("top_go_lsel", controlSig, 1);
        drive(0, 0, 0, 1, 0);
        chk("replay_tl", timeLeft, 60);
        n_ticks(43);
        chk("pre_end_tl", timeLeft, 17);
        drive(0, 0, 0, 0, 1);
        chk("ge_cs", controlSig, 3);
        chk("ge_tl", timeLeft, 17);
        chk("ge_tu", timeUp, 0);
        n_ticks(2);
        chk("ge_tl_hold", timeLeft, 17);
        chk("ge_score", controlSig, 3);

        // gameEnd with a non-final tick: event wins, timer frozen
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        n_ticks(10);
        drive(1, 0, 0, 0, 1);
        chk("ge_tick_cs", controlSig, 3);
        chk("ge_tick_tl", timeLeft, 50);
        chk("ge_tick_tu", timeUp, 0);

        // gameEnd with the final tick
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        n_ticks(59);
        chk("pre_fin_tl", timeLeft, 1);
        drive(1, 0, 0, 0, 1);
        chk("fin_cs", controlSig, 3);
        chk("fin_tl", timeLeft, 0);
        chk("fin_tu", timeUp, 1);
        drive(0, 0, 0, 0, 0);
        chk("fin_tu_drop", timeUp, 0);

        // logout priority in PLAY
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        n_ticks(5);
        drive(1, 0, 1, 1, 0);
        chk("lo_cs", controlSig, 0);
        chk("lo_tl", timeLeft, 0);
        chk("lo_ga", gameActive, 0);

        // async reset mid-PLAY
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_ticks(3);
        chk("pre_rst_tl", timeLeft, 57);
        rst = 0;
        #1;
        chk("arst_cs", controlSig, 0);
        chk("arst_tl", timeLeft, 0);
        chk("arst_ga", gameActive, 0);
        @(posedge clk); #1;
        rst = 1;
        drive(0, 0, 0, 1, 0);
        chk("post_rst_out", controlSig, 0);
        drive(0, 1, 0, 0, 0);
        chk("post_rst_login", controlSig, 1);

`ifdef DISP_SEQ_AUTO_LOGOUT_EN
        n_ticks(29);
        chk("idle_29", controlSig, 1);
        do_tick();
        chk("idle_30", controlSig, 0);
        drive(0, 1, 0, 0, 0);
        n_ticks(28);
        drive(1, 0, 0, 1, 0);
        chk("idle_go", controlSig, 2);
`else
        n_ticks(100);
        chk("no_idle", controlSig, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_sequencer.md
DISP_SEQUENCER -- requirements
Module: disp_sequencer

Interface
REQ-001 Parameter: GAME_SECONDS, default 60, game length in tick periods (1..63).
REQ-002 Parameter: SCORE_TICKS, default 3, ticks the player score (controlSig=3) is held after a game.
REQ-003 Parameter: ALT_TICKS, default 2, ticks per phase of the top-ID/top-score alternation.
REQ-004 Parameter: IDLE_TICKS, default 30, inactivity ticks before auto-logout; used only with AUTO_LOGOUT_EN.
REQ-005 Port: clk  input  1  system clock, all state changes on rising edge.
REQ-006 Port: rst  input  1  reset, asynchronous, active-low.
REQ-007 Port: tick  input  1  one-cycle pulse, once per second, synchronous to clk.
REQ-008 Port: loginOk  input  1  one-cycle pulse, player ID accepted.
REQ-009 Port: logoutReq  input  1  one-cycle pulse, player requests logout.
REQ-010 Port: levelGo  input  1  one-cycle pulse, level confirmed or play again requested.
REQ-011 Port: gameEnd  input  1  one-cycle pulse, all words solved before the timer expires.
REQ-012 Port: controlSig  output  3  display-mux select, registered.
REQ-013 Port: timeLeft  output  6  seconds remaining in the current game, registered.
REQ-014 Port: gameActive  output  1  high while controlSig=2.
REQ-015 Port: timeUp  output  1  one-cycle pulse when the game timer reaches zero.

Function
REQ-016 States, with controlSig equal to the encoding: OUT=0, LSEL=1, PLAY=2, SCORE=3, TOPID=4, TOPSC=5; encodings 6/7 unreachable, recover to OUT on the next edge.
REQ-017 OUT -> LSEL on loginOk; all other inputs ignored in OUT.
REQ-018 LSEL -> PLAY on levelGo; timeLeft loads GAME_SECONDS on the same edge.
REQ-019 PLAY: each tick decrements timeLeft; the tick that takes timeLeft from 1 to 0 asserts timeUp for that one cycle (registered, the cycle after the edge) and moves to SCORE.
REQ-020 PLAY -> SCORE on gameEnd; timeLeft freezes at its current value and timeUp stays low.
REQ-021 gameEnd and the final tick in the same cycle: go to SCORE, timeLeft=0, timeUp asserted.
REQ-022 SCORE: hold for SCORE_TICKS ticks, counted from entry, then go to TOPID.
REQ-023 TOPID <-> TOPSC alternate every ALT_TICKS ticks, indefinitely.
REQ-024 In SCORE, TOPID or TOPSC, levelGo goes to LSEL on the next edge and clears the phase counter.
REQ-025 logoutReq in any state other than OUT goes to OUT on the next edge, has priority over every other input, and clears timeLeft and all counters.
REQ-026 An event transition and a tick in the same cycle: the transition wins and the tick is not counted in the new state.
REQ-027 Entry into any state resets the phase counter to 0; the counter is wide enough for max(SCORE_TICKS, ALT_TICKS, IDLE_TICKS) and never wraps.
REQ-028 gameActive = (state==PLAY), registered together with controlSig; no output is combinational from an input.
REQ-029 Latency: every state change is visible on controlSig one clk after the causing input pulse.

Reset
REQ-030 rst low asynchronously forces state=OUT, controlSig=0, timeLeft=0, gameActive=0, timeUp=0 and clears all counters.
REQ-031 rst asserted mid-game discards the game; after release the block waits in OUT for loginOk.

Configuration
REQ-032 Macro DISP_SEQ_AUTO_LOGOUT_EN defined: in LSEL, TOPID or TOPSC, IDLE_TICKS consecutive ticks with no loginOk/levelGo/logoutReq force OUT; any of those inputs restarts the idle count.
REQ-033 Macro not defined: no idle counter is built, IDLE_TICKS is unused, and those states are held indefinitely.

Verification
REQ-034 Reset, loginOk, then levelGo -> controlSig 0,1,2; timeLeft=60 on the cycle after levelGo.
REQ-035 PLAY with 60 ticks -> timeLeft counts 59..0, timeUp pulses once at 0, controlSig=3; after 3 ticks controlSig=4; after 2 more ticks controlSig=5; after 2 more ticks controlSig=4.
REQ-036 gameEnd at timeLeft=17 -> controlSig=3, timeLeft holds 17, no timeUp; gameEnd together with the final tick -> timeUp=1, timeLeft=0.
REQ-037 logoutReq together with tick and levelGo in PLAY -> controlSig=0 and timeLeft=0 next cycle; rst low mid-PLAY -> outputs 0 immediately, without a clk edge.
REQ-038 With DISP_SEQ_AUTO_LOGOUT_EN defined, 30 idle ticks in LSEL -> controlSig=0; a levelGo pulse at tick 29 takes the block to PLAY instead. Without the macro, 100 idle ticks leave controlSig=1.
